// File: rtl/framebuffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// framebuffer_write_arbiter
//
// Purpose: arbitrates single-pixel draw requests and a full-frame clear sweep
// onto one framebuffer write port. A clear fills every pixel with COLOR_BLACK
// in raster order, one pixel per cycle. A draw writes one pixel, one cycle
// after it is sampled.
//
// Handshake (draw side): the requester raises draw_req and holds draw_x,
// draw_y and draw_color stable until it sees draw_ack. draw_ack is a
// one-cycle pulse. If draw_req is still high in the IDLE cycle after the ack,
// it is taken as a new request. Draws are stalled, with no ack, while a clear
// is running.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   clear_start                one-cycle request to clear the whole frame
//   clear_busy / clear_done    sweep in progress / final clear write
//   draw_req, draw_x, draw_y,
//   draw_color, draw_ack       pixel draw request and its acknowledge
//   fb_we, fb_x, fb_y,
//   fb_color                   framebuffer write port (registered)
//   dbg_state                  current FSM state, for observation
// -----------------------------------------------------------------------------
package common_pkg;
    localparam int COLOR_WIDTH = 4;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 4'd0;
    localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd1;
    localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd2;
    localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd3;
    localparam logic [COLOR_WIDTH-1:0] COLOR_WHITE = 4'd7;
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } fbwa_state_t;
endpackage

module framebuffer_write_arbiter
    import common_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done,
    input  logic                   draw_req,
    input  logic [9:0]             draw_x,
    input  logic [9:0]             draw_y,
    input  logic [COLOR_WIDTH-1:0] draw_color,
    output logic                   draw_ack,
    output logic                   fb_we,
    output logic [9:0]             fb_x,
    output logic [9:0]             fb_y,
    output logic [COLOR_WIDTH-1:0] fb_color,
    output fbwa_state_t            dbg_state
);

    localparam logic [9:0] X_MAX = 10'(FB_WIDTH - 1);
    localparam logic [9:0] Y_MAX = 10'(FB_HEIGHT - 1);

    fbwa_state_t state;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;

    // Next raster position of the clear sweep. The counters always hold the
    // address being written in the current CLEAR cycle.
    logic       x_last;
    logic       y_last;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       draw_visible;

    always_comb begin
        x_last = (x_cnt == X_MAX);
        y_last = (y_cnt == Y_MAX);
        x_next = x_last ? 10'd0 : x_cnt + 10'd1;
        y_next = x_last ? y_cnt + 10'd1 : y_cnt;
        // Transparent or off-screen draws are acknowledged but not written.
        draw_visible = (draw_color != COLOR_NONE) &&
                       (draw_x <= X_MAX) && (draw_y <= Y_MAX);
    end

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            x_cnt      <= 10'd0;
            y_cnt      <= 10'd0;
            draw_ack   <= 1'b0;
            fb_we      <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            fb_x       <= 10'd0;
            fb_y       <= 10'd0;
            fb_color   <= COLOR_BLACK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        // Clear wins over a simultaneous draw; the draw stays
                        // pending and is served once the sweep finishes.
                        state      <= ST_CLEAR;
                        x_cnt      <= 10'd0;
                        y_cnt      <= 10'd0;
                        fb_we      <= 1'b1;
                        fb_x       <= 10'd0;
                        fb_y       <= 10'd0;
                        fb_color   <= COLOR_BLACK;
                        clear_busy <= 1'b1;
                        clear_done <= 1'b0;
                        draw_ack   <= 1'b0;
                    end else if (draw_req) begin
                        state    <= ST_WRITE;
                        draw_ack <= 1'b1;
                        fb_we    <= draw_visible;
                        // Address and data only move on a real write so the
                        // port holds its last values otherwise.
                        if (draw_visible) begin
                            fb_x     <= draw_x;
                            fb_y     <= draw_y;
                            fb_color <= draw_color;
                        end
                    end else begin
                        draw_ack <= 1'b0;
                        fb_we    <= 1'b0;
                    end
                end

                ST_WRITE: begin
                    state    <= ST_IDLE;
                    draw_ack <= 1'b0;
                    fb_we    <= 1'b0;
                end

                ST_CLEAR: begin
                    if (x_last && y_last) begin
                        state      <= ST_IDLE;
                        fb_we      <= 1'b0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b0;
                    end else begin
                        x_cnt      <= x_next;
                        y_cnt      <= y_next;
                        fb_we      <= 1'b1;
                        fb_x       <= x_next;
                        fb_y       <= y_next;
                        fb_color   <= COLOR_BLACK;
                        clear_done <= (x_next == X_MAX) && (y_next == Y_MAX);
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    draw_ack   <= 1'b0;
                    fb_we      <= 1'b0;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_framebuffer_write_arbiter
//
// Directed bench for framebuffer_write_arbiter with a 4x3 frame. Inputs change
// 1 time unit after a rising edge; outputs are checked at the same point, so
// every check observes the registered result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_framebuffer_write_arbiter;
    import common_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   clear_start = 1'b0;
    logic                   clear_busy;
    logic                   clear_done;
    logic                   draw_req = 1'b0;
    logic [9:0]             draw_x = 10'd0;
    logic [9:0]             draw_y = 10'd0;
    logic [COLOR_WIDTH-1:0] draw_color = COLOR_BLACK;
    logic                   draw_ack;
    logic                   fb_we;
    logic [9:0]             fb_x;
    logic [9:0]             fb_y;
    logic [COLOR_WIDTH-1:0] fb_color;
    fbwa_state_t            dbg_state;

    int checks = 0;
    int errors = 0;

    framebuffer_write_arbiter #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .draw_req    (draw_req),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_color  (draw_color),
        .draw_ack    (draw_ack),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_color    (fb_color),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write-port snapshot: enable, address, data, ack.
    task automatic check_port(input string tag, input logic we, input logic ack,
                              input logic [9:0] x, input logic [9:0] y,
                              input logic [COLOR_WIDTH-1:0] c);
        check({tag, ".fb_we"},    32'(fb_we),    32'(we));
        check({tag, ".draw_ack"}, 32'(draw_ack), 32'(ack));
        check({tag, ".fb_x"},     32'(fb_x),     32'(x));
        check({tag, ".fb_y"},     32'(fb_y),     32'(y));
        check({tag, ".fb_color"}, 32'(fb_color), 32'(c));
    endtask

    task automatic set_draw(input logic req, input int x, input int y,
                            input logic [COLOR_WIDTH-1:0] c);
        draw_req   = req;
        draw_x     = 10'(x);
        draw_y     = 10'(y);
        draw_color = c;
    endtask

    // Caller raises clear_start before calling. Checks all W*H clear writes,
    // and re-pulses clear_start mid-sweep to confirm it does not restart.
    task automatic run_clear(input string tag);
        for (int i = 0; i < W * H; i++) begin
            step();
            if (i == 0) clear_start = 1'b0;
            if (i == 3) clear_start = 1'b1;
            if (i == 4) clear_start = 1'b0;
            check_port($sformatf("%s.w%0d", tag, i), 1'b1, 1'b0,
                       10'(i % W), 10'(i / W), COLOR_BLACK);
            check($sformatf("%s.busy%0d", tag, i), 32'(clear_busy), 32'd1);
            check($sformatf("%s.done%0d", tag, i), 32'(clear_done),
                  32'(i == W * H - 1));
        end
    endtask

    initial begin
        // Reset
        step();
        step();
        check_port("rst", 1'b0, 1'b0, 10'd0, 10'd0, COLOR_BLACK);
        check("rst.busy", 32'(clear_busy), 32'd0);
        check("rst.done", 32'(clear_done), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        step();
        check_port("idle", 1'b0, 1'b0, 10'd0, 10'd0, COLOR_BLACK);

        // Single draw, one-cycle ack and write
        set_draw(1'b1, 2, 1, COLOR_RED);
        step();
        check_port("draw", 1'b1, 1'b1, 10'd2, 10'd1, COLOR_RED);
        check("draw.state", 32'(dbg_state), 32'(ST_WRITE));
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        check_port("draw.after", 1'b0, 1'b0, 10'd2, 10'd1, COLOR_RED);
        check("draw.after.state", 32'(dbg_state), 32'(ST_IDLE));

        // Full clear sweep
        clear_start = 1'b1;
        run_clear("clr");
        step();
        check_port("clr.end", 1'b0, 1'b0, 10'd3, 10'd2, COLOR_BLACK);
        check("clr.end.busy", 32'(clear_busy), 32'd0);
        check("clr.end.done", 32'(clear_done), 32'd0);
        step();
        check("clr.end2.we", 32'(fb_we), 32'd0);

        // Collision: clear wins, draw served after the sweep
        clear_start = 1'b1;
        set_draw(1'b1, 1, 2, COLOR_GREEN);
        run_clear("col");
        step();
        check_port("col.idle", 1'b0, 1'b0, 10'd3, 10'd2, COLOR_BLACK);
        step();
        check_port("col.draw", 1'b1, 1'b1, 10'd1, 10'd2, COLOR_GREEN);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        check_port("col.after", 1'b0, 1'b0, 10'd1, 10'd2, COLOR_GREEN);

        // Filtered draws: off-screen x, off-screen y, transparent
        set_draw(1'b1, 5, 0, COLOR_RED);
        step();
        check_port("flt.x", 1'b0, 1'b1, 10'd1, 10'd2, COLOR_GREEN);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        set_draw(1'b1, 0, 3, COLOR_WHITE);
        step();
        check_port("flt.y", 1'b0, 1'b1, 10'd1, 10'd2, COLOR_GREEN);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        set_draw(1'b1, 0, 2, COLOR_NONE);
        step();
        check_port("flt.none", 1'b0, 1'b1, 10'd1, 10'd2, COLOR_GREEN);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        // Corner pixel is on-screen
        set_draw(1'b1, 3, 2, COLOR_BLUE);
        step();
        check_port("corner", 1'b1, 1'b1, 10'd3, 10'd2, COLOR_BLUE);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();

        // Reset after the 5th clear write aborts the sweep
        clear_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) clear_start = 1'b0;
            check_port($sformatf("abort.w%0d", i), 1'b1, 1'b0,
                       10'(i % W), 10'(i / W), COLOR_BLACK);
        end
        reset = 1'b1;
        step();
        check_port("abort.rst", 1'b0, 1'b0, 10'd0, 10'd0, COLOR_BLACK);
        check("abort.rst.busy", 32'(clear_busy), 32'd0);
        check("abort.rst.done", 32'(clear_done), 32'd0);
        reset = 1'b0;
        step();
        step();
        check("abort.noresume.we", 32'(fb_we), 32'd0);
        check("abort.noresume.busy", 32'(clear_busy), 32'd0);
        clear_start = 1'b1;
        run_clear("restart");
        step();
        check("restart.end.busy", 32'(clear_busy), 32'd0);

        // Inputs present at a reset edge are ignored
        reset = 1'b1;
        set_draw(1'b1, 3, 0, COLOR_BLUE);
        step();
        check_port("rstin", 1'b0, 1'b0, 10'd0, 10'd0, COLOR_BLACK);
        reset = 1'b0;
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        check_port("rstin.after", 1'b0, 1'b0, 10'd0, 10'd0, COLOR_BLACK);

        // Back-to-back draws with draw_req held high
        set_draw(1'b1, 1, 0, COLOR_RED);
        step();
        check_port("b2b.0", 1'b1, 1'b1, 10'd1, 10'd0, COLOR_RED);
        set_draw(1'b1, 2, 1, COLOR_GREEN);
        step();
        check_port("b2b.gap0", 1'b0, 1'b0, 10'd1, 10'd0, COLOR_RED);
        step();
        check_port("b2b.1", 1'b1, 1'b1, 10'd2, 10'd1, COLOR_GREEN);
        set_draw(1'b1, 3, 2, COLOR_WHITE);
        step();
        check_port("b2b.gap1", 1'b0, 1'b0, 10'd2, 10'd1, COLOR_GREEN);
        step();
        check_port("b2b.2", 1'b1, 1'b1, 10'd3, 10'd2, COLOR_WHITE);
        set_draw(1'b0, 0, 0, COLOR_BLACK);
        step();
        check_port("b2b.end", 1'b0, 1'b0, 10'd3, 10'd2, COLOR_WHITE);
        step();
        check("b2b.end2.ack", 32'(draw_ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/framebuffer_write_arbiter.md
FRAMEBUFFER_WRITE_ARBITER -- requirements
Module: framebuffer_write_arbiter

Interface
REQ-001 Parameter FB_WIDTH, default 640, pixels per row; legal range 2..1024.
REQ-002 Parameter FB_HEIGHT, default 480, rows per frame; legal range 2..1024.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear_start  input  1  one-cycle request to fill the whole frame with COLOR_BLACK.
REQ-006 clear_busy  output  1  high while the clear sweep is in progress.
REQ-007 clear_done  output  1  one-cycle pulse on the final clear write.
REQ-008 draw_req  input  1  pixel-draw request; held with stable data until acknowledged.
REQ-009 draw_x / draw_y  input  10 / 10  draw coordinates.
REQ-010 draw_color  input  COLOR_WIDTH  color index from common.sv.
REQ-011 draw_ack  output  1  one-cycle acknowledge of a draw request.
REQ-012 fb_we  output  1  framebuffer write enable.
REQ-013 fb_x / fb_y  output  10 / 10  framebuffer write address.
REQ-014 fb_color  output  COLOR_WIDTH  framebuffer write data; never COLOR_NONE while fb_we is high.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WRITE and CLEAR.
REQ-016 In IDLE with clear_start high, the next state SHALL be CLEAR, with the x and y counters loaded to 0; clear_start has priority over a simultaneous draw_req.
REQ-017 In IDLE with draw_req high and clear_start low, the block SHALL register draw_x, draw_y and draw_color, and the next state SHALL be WRITE.
REQ-018 WRITE SHALL last exactly one cycle, with draw_ack high, and SHALL then return to IDLE.
REQ-019 In WRITE, fb_we SHALL be high with the registered coordinates and color, except in two cases:
  - fb_we SHALL be low when the registered color is COLOR_NONE (transparent draw);
  - fb_we SHALL be low when x >= FB_WIDTH or y >= FB_HEIGHT.
  draw_ack SHALL still assert in both cases.
REQ-020 Draw latency from the sampling edge to draw_ack/fb_we SHALL be one cycle; the maximum draw throughput is one pixel per two cycles.
REQ-021 A requester keeping draw_req high after draw_ack SHALL be treated as a new request in the following IDLE cycle.
REQ-022 In CLEAR, each cycle SHALL drive fb_we=1, fb_x=x, fb_y=y, fb_color=COLOR_BLACK.
REQ-023 Clear counters SHALL advance in raster order: x increments; at x=FB_WIDTH-1, x wraps to 0 and y increments.
REQ-024 The write of (FB_WIDTH-1, FB_HEIGHT-1) SHALL be the final clear write, with clear_done high in the same cycle; the next state SHALL be IDLE.
REQ-025 A clear SHALL take exactly FB_WIDTH*FB_HEIGHT cycles, with clear_busy high during every one of them.
REQ-026 In CLEAR:
  - clear_start SHALL be ignored (no restart);
  - draw_req SHALL be stalled with draw_ack low, and SHALL be served in the first IDLE cycle after the clear.
REQ-027 In any cycle without a write, fb_x, fb_y and fb_color SHALL hold their last values.
REQ-028 draw_ack, fb_we and clear_done SHALL never be high outside WRITE or CLEAR.

Reset
REQ-029 While reset is high at a clock edge, the next state SHALL be IDLE, with:
  - counters = 0;
  - draw_ack = fb_we = clear_busy = clear_done = 0;
  - fb_x = fb_y = 0, fb_color = COLOR_BLACK.
REQ-030 Reset asserted mid-CLEAR or mid-WRITE SHALL abort the operation, with no further fb_we from the cycle after the reset edge; a resumed clear SHALL restart from (0,0) only on a new clear_start.
REQ-031 Inputs sampled during a reset edge SHALL be ignored.

Verification (FB_WIDTH=4, FB_HEIGHT=3)
REQ-032 Draw: draw_req=1, (2,1), COLOR_RED in IDLE -> next cycle draw_ack=1, fb_we=1, fb_x=2, fb_y=1, fb_color=COLOR_RED, each for exactly one cycle.
REQ-033 Clear: clear_start pulse -> 12 consecutive cycles with fb_we=1, COLOR_BLACK, addresses (0,0),(1,0)..(3,0),(0,1)..(3,2); clear_done only with (3,2); clear_busy low afterwards.
REQ-034 Collision: clear_start and draw_req together -> 12 clear writes, no draw_ack; draw served (ack+write) one cycle after the clear ends.
REQ-035 Filtered draws: draw at (5,0) or with COLOR_NONE -> draw_ack=1, fb_we=0.
REQ-036 Reset: reset after the 5th clear write -> fb_we=0 and clear_busy=0 from the next cycle; a new clear_start restarts at (0,0).
REQ-037 Back-to-back: draw_req held high for 3 requests -> acks spaced exactly 2 cycles apart, each write matching its data.
